// File: rtl/instr_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
//   Shared types and constants for the instruction-memory responder.
//   - imem_resp_t  : one response slot travelling down the latency pipeline
//   - resp_advance : next-state rule for a pipeline slot (valid always moves,
//                    payload only moves with a valid entry so the outputs hold
//                    their last value between responses)
// -----------------------------------------------------------------------------
package instr_mem_pkg;

    localparam int IMEM_MAX_LATENCY = 4;
    localparam int WORD_BYTES       = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } imem_resp_t;

    localparam imem_resp_t IMEM_RESP_IDLE = '0;

    // A bubble advances as a bubble but leaves the slot's payload untouched.
    function automatic imem_resp_t resp_advance(input imem_resp_t src,
                                                input imem_resp_t held);
        imem_resp_t nxt;
        nxt       = src.valid ? src : held;
        nxt.valid = src.valid;
        return nxt;
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// -----------------------------------------------------------------------------
// instr_mem_responder_if
//   Fetch-side bus of the instruction memory: req/gnt/rvalid handshake,
//   grant backpressure and the preload write port.
//   master : fetch stage / bench (drives requests and preload)
//   slave  : instr_mem_responder
// -----------------------------------------------------------------------------
interface instr_mem_responder_if;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        gnt_stall_i;
    logic        ld_we_i;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_wdata_i;

    modport master (
        output instr_req_i, instr_addr_i, gnt_stall_i,
               ld_we_i, ld_addr_i, ld_wdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i, gnt_stall_i,
               ld_we_i, ld_addr_i, ld_wdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

endinterface

// File: rtl/instr_mem_responder_delay.sv
// -----------------------------------------------------------------------------
// instr_resp_delay
//   LATENCY-stage shift register of imem_resp_t. A response written at the
//   grant edge appears on resp_o exactly LATENCY cycles later; one entry per
//   cycle, strictly in order.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   asynchronous reset, active-high; empties every stage
//     resp_i  in   response captured at the grant edge (valid = transfer)
//     resp_o  out  last stage; payload holds while valid is low
// -----------------------------------------------------------------------------
module instr_resp_delay
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  imem_resp_t resp_i,
    output imem_resp_t resp_o
);

    imem_resp_t stage_q [LATENCY];
    imem_resp_t stage_d [LATENCY];

    always_comb begin
        stage_d[0] = resp_advance(resp_i, stage_q[0]);
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k] = resp_advance(stage_q[k-1], stage_q[k]);
        end
    end

    // Payload is cleared along with valid so rdata/err read zero after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every stage
    // samples the pre-edge value of its neighbour and the shift is race-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= IMEM_RESP_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
//   Memory-side responder of the instruction-fetch req/gnt/rvalid interface.
//   Grants requests while fewer than MAX_OUTSTANDING are in flight, reads the
//   word-wide instruction array in the grant cycle and returns the response
//   LATENCY cycles later, in order. Addresses outside the array window answer
//   with err=1 and rdata=0. A preload port writes the array for test/boot.
//   Parameters:
//     MEM_WORDS        words in the array
//     BASE_ADDR        byte address of word 0 (4-byte aligned)
//     LATENCY          grant-to-rvalid cycles, 1..IMEM_MAX_LATENCY
//     MAX_OUTSTANDING  granted-but-unanswered limit, 1..LATENCY+1
//   Ports:
//     clk  in   clock, rising edge
//     rst  in   asynchronous reset, active-high (gnt forced low while high)
//     bus  slave modport of instr_mem_responder_if:
//          instr_req_i/instr_addr_i  fetch request, byte address
//          instr_gnt_o               combinational grant
//          instr_rvalid_o/rdata/err  response, err qualified by rvalid
//          gnt_stall_i               external backpressure on the grant
//          ld_we_i/ld_addr_i/wdata   preload write port
// -----------------------------------------------------------------------------
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                  clk,
    input logic                  rst,
    instr_mem_responder_if.slave bus
);

    localparam int               IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      WORD_LIMIT = 32'(MEM_WORDS);
    localparam int               WORD_SHIFT = $clog2(WORD_BYTES);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (LATENCY < 1 || LATENCY > IMEM_MAX_LATENCY) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be 1..%0d", IMEM_MAX_LATENCY);
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
        $error("instr_mem_responder: MAX_OUTSTANDING must be 1..LATENCY+1");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("instr_mem_responder: BASE_ADDR must be word aligned");
    end
    if (MEM_WORDS < 1) begin : g_bad_words
        $error("instr_mem_responder: MEM_WORDS must be at least 1");
    end

    // ------------------------------------------------------------------
    // Address decode. The subtraction is done before the shift so the
    // low two bits never matter, and the range test is a plain 32-bit
    // compare: an address below BASE_ADDR would wrap to a huge index, which
    // is why the lower bound is checked separately.
    // ------------------------------------------------------------------
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return (byte_addr - BASE_ADDR) >> WORD_SHIFT;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] byte_addr);
        return (byte_addr >= BASE_ADDR) && (word_index(byte_addr) < WORD_LIMIT);
    endfunction

    logic [31:0]      mem [MEM_WORDS];
    logic             fetch_in_range;
    logic [IDX_W-1:0] fetch_idx;
    logic [31:0]      fetch_word;
    logic             ld_in_range;
    logic [IDX_W-1:0] ld_idx;
    logic             gnt;
    logic             transfer;
    logic             rvalid;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    imem_resp_t       resp_in;
    imem_resp_t       resp_out;

    always_comb begin
        fetch_in_range = addr_in_range(bus.instr_addr_i);
        fetch_idx      = IDX_W'(word_index(bus.instr_addr_i));
        ld_in_range    = addr_in_range(bus.ld_addr_i);
        ld_idx         = IDX_W'(word_index(bus.ld_addr_i));
    end

    // ------------------------------------------------------------------
    // Grant: only the registered count gates it, so a slot freed by this
    // cycle's rvalid becomes usable on the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        gnt      = ~rst & bus.instr_req_i & ~bus.gnt_stall_i & (outstanding_q < MAX_CNT);
        transfer = bus.instr_req_i & gnt;
    end

    // ------------------------------------------------------------------
    // Array: asynchronous read in the grant cycle, write at the clock edge.
    // A same-cycle write to the word being read therefore returns old data.
    // NOTE: the array has no reset; only control state is reset, which keeps
    // it mappable to SRAM and lets preloaded contents survive a reset pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.ld_we_i && ld_in_range) begin
            mem[ld_idx] <= bus.ld_wdata_i;
        end
    end

    assign fetch_word = mem[fetch_idx];

    always_comb begin
        resp_in.valid = transfer;
        resp_in.err   = ~fetch_in_range;
        resp_in.data  = fetch_in_range ? fetch_word : 32'h0;
    end

    instr_resp_delay #(
        .LATENCY (LATENCY)
    ) u_resp_delay (
        .clk    (clk),
        .rst    (rst),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign rvalid = resp_out.valid;

    // ------------------------------------------------------------------
    // Outstanding counter: +1 per transfer, -1 per response, unchanged
    // when both happen together. The grant limit keeps it within range.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves outstanding_d
        // unassigned, which would otherwise infer a latch.
        outstanding_d = outstanding_q;
        case ({transfer, rvalid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.instr_gnt_o    = gnt;
    assign bus.instr_rvalid_o = rvalid;
    assign bus.instr_rdata_o  = resp_out.data;
    assign bus.instr_err_o    = resp_out.err;

endmodule
